// File: rtl/rptr_empty_if.sv
// rptr_empty_if
//   Read-side bundle between the FIFO read port logic and the read pointer /
//   empty-flag block.
//   master : the surrounding read logic (drives rinc and the synchronized
//            write pointer, consumes the address, pointer and flags)
//   slave  : rptr_empty itself
//   Signals:
//     rinc        read request
//     rq2_wptr    Gray write pointer already synchronized into the read clock
//     raddr       binary RAM read address
//     rptr        registered Gray read pointer, exported to the write domain
//     rempty      [0] empty, [1] almost-empty (exactly one entry readable)
//     rlevel      registered fill estimate, 0..2^ADDRSIZE
//     runderflow  one-cycle pulse when a read is rejected
interface rptr_empty_if #(
   parameter int ADDRSIZE = 4
);
   logic                rinc;
   logic [ADDRSIZE:0]   rq2_wptr;
   logic [ADDRSIZE-1:0] raddr;
   logic [ADDRSIZE:0]   rptr;
   logic [1:0]          rempty;
   logic [ADDRSIZE:0]   rlevel;
   logic                runderflow;

   modport master (
      output rinc,
      output rq2_wptr,
      input  raddr,
      input  rptr,
      input  rempty,
      input  rlevel,
      input  runderflow
   );

   modport slave (
      input  rinc,
      input  rq2_wptr,
      output raddr,
      output rptr,
      output rempty,
      output rlevel,
      output runderflow
   );
endinterface

// File: rtl/rptr_empty.sv
// rptr_empty
//   Read-domain pointer and empty-flag generator of the dual-clock FIFO.
//   Keeps a binary read counter (low bits address the RAM) and a Gray copy
//   handed to the write domain. Against the synchronized Gray write pointer it
//   registers empty / almost-empty flags, a fill-level estimate and an
//   underflow strobe. All outputs are registered and move on the same edge.
//   Ports:
//     i_rclk  read clock
//     i_rrst  synchronous active-high reset
//     bus     rptr_empty_if.slave (rinc, rq2_wptr in; raddr, rptr, rempty,
//             rlevel, runderflow out)
module rptr_empty #(
   parameter int ADDRSIZE = 4
) (
   input  logic         i_rclk,
   input  logic         i_rrst,
   rptr_empty_if.slave  bus
);

   logic [ADDRSIZE:0] r_bin;
   logic [ADDRSIZE:0] r_ptr;
   logic [ADDRSIZE:0] r_level;
   logic [1:0]        r_empty;
   logic              r_underflow;

   logic              w_accept;
   logic [ADDRSIZE:0] w_binnext;
   logic [ADDRSIZE:0] w_bin2next;
   logic [ADDRSIZE:0] w_graynext;
   logic [ADDRSIZE:0] w_gray2next;
   logic [ADDRSIZE:0] w_wbin;

   function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
      logic [ADDRSIZE:0] b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // A read is taken only against the registered empty flag, so a rejected
   // request never moves the pointers.
   assign w_accept    = bus.rinc & ~r_empty[0];
   assign w_binnext   = r_bin + {{ADDRSIZE{1'b0}}, w_accept};
   assign w_bin2next  = w_binnext + {{ADDRSIZE{1'b0}}, 1'b1};
   assign w_graynext  = (w_binnext >> 1) ^ w_binnext;
   assign w_gray2next = (w_bin2next >> 1) ^ w_bin2next;
   assign w_wbin      = gray2bin(bus.rq2_wptr);

   // Flags and level are computed from the post-read pointer so they already
   // account for a read accepted on this edge. Full-width Gray compares keep
   // the wrap bit, so a full FIFO is never mistaken for an empty one.
   always_ff @(posedge i_rclk) begin
      if (i_rrst) begin
         r_bin       <= '0;
         r_ptr       <= '0;
         r_empty     <= 2'b01;
         r_level     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_bin       <= w_binnext;
         r_ptr       <= w_graynext;
         r_empty     <= {(w_gray2next == bus.rq2_wptr), (w_graynext == bus.rq2_wptr)};
         r_level     <= w_wbin - w_binnext;
         r_underflow <= bus.rinc & r_empty[0];
      end
   end

   assign bus.raddr      = r_bin[ADDRSIZE-1:0];
   assign bus.rptr       = r_ptr;
   assign bus.rempty     = r_empty;
   assign bus.rlevel     = r_level;
   assign bus.runderflow = r_underflow;

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

   typedef struct packed {
      logic [4:0] rptr;
      logic [3:0] raddr;
      logic [1:0] rempty;
      logic [4:0] rlevel;
      logic       runder;
   } obs_t;

   logic clk;
   logic rrst;
   int   n_checks;
   int   n_fail;

   // Reference model state: plain integer read/write counts.
   int   m_rbin;
   logic m_empty;
   int   wcnt;
   obs_t sb[$];

   rptr_empty_if #(.ADDRSIZE(4)) bus ();

   rptr_empty #(.ADDRSIZE(4)) dut (
      .i_rclk (clk),
      .i_rrst (rrst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] gray5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rptr   = bus.rptr;
      o.raddr  = bus.raddr;
      o.rempty = bus.rempty;
      o.rlevel = bus.rlevel;
      o.runder = bus.runderflow;
      return o;
   endfunction

   // Drive one cycle of stimulus, push the model's expectation, and return
   // just after the active edge.
   task automatic drive(input logic inc, input logic rst, input int wnew);
      obs_t e;
      int   lvl;
      logic [4:0] wb;
      logic [4:0] rb;
      @(negedge clk);
      rrst         = rst;
      bus.rinc     = inc;
      wcnt         = wnew;
      wb           = wnew[4:0];
      bus.rq2_wptr = gray5(wb);
      if (rst) begin
         m_rbin  = 0;
         m_empty = 1'b1;
         e       = '{rptr: 5'd0, raddr: 4'd0, rempty: 2'b01, rlevel: 5'd0, runder: 1'b0};
      end else begin
         e.runder = inc && m_empty;
         if (inc && !m_empty) m_rbin = m_rbin + 1;
         lvl      = (wnew - m_rbin) & 31;
         m_empty  = (lvl == 0);
         rb       = m_rbin[4:0];
         e.rptr   = gray5(rb);
         e.raddr  = rb[3:0];
         e.rempty = {(lvl == 1), (lvl == 0)};
         e.rlevel = lvl[4:0];
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 0);
         e = sb.pop_front(); o = sample(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b, need rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b",
                     i, o.rptr, o.raddr, o.rempty, o.rlevel, o.runder, e.rptr, e.raddr, e.rempty, e.rlevel, e.runder);
         end
      end
   endtask

   task automatic test_single();
      obs_t e, o;
      drive(1'b0, 1'b0, 1);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e || o.rempty !== 2'b10) begin
         n_fail++;
         $display("FAIL single_avail: got rempty=%b rlevel=%0d, need rempty=%b rlevel=%0d",
                  o.rempty, o.rlevel, e.rempty, e.rlevel);
      end
      drive(1'b1, 1'b0, 1);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e || o.rptr !== 5'b00001) begin
         n_fail++;
         $display("FAIL single_read: got rptr=%b raddr=%0d rempty=%b rlevel=%0d, need rptr=%b raddr=%0d rempty=%b rlevel=%0d",
                  o.rptr, o.raddr, o.rempty, o.rlevel, e.rptr, e.raddr, e.rempty, e.rlevel);
      end
   endtask

   task automatic test_underflow();
      obs_t e, o;
      logic [2:0] pat;
      pat = 3'b011;
      for (int i = 0; i < 3; i++) begin
         drive(pat[i], 1'b0, wcnt);
         e = sb.pop_front(); o = sample(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL underflow[%0d]: got rptr=%b und=%b rempty=%b, need rptr=%b und=%b rempty=%b",
                     i, o.rptr, o.runder, o.rempty, e.rptr, e.runder, e.rempty);
         end
      end
   endtask

   task automatic test_full_drain();
      obs_t e, o;
      drive(1'b0, 1'b1, 0);
      void'(sb.pop_front());
      drive(1'b0, 1'b0, 16);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e || o.rlevel !== 5'd16) begin
         n_fail++;
         $display("FAIL full_level: got rlevel=%0d rempty=%b, need rlevel=%0d rempty=%b",
                  o.rlevel, o.rempty, e.rlevel, e.rempty);
      end
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0, 16);
         e = sb.pop_front(); o = sample(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL drain[%0d]: got rptr=%b raddr=%0d rempty=%b rlevel=%0d, need rptr=%b raddr=%0d rempty=%b rlevel=%0d",
                     i, o.rptr, o.raddr, o.rempty, o.rlevel, e.rptr, e.raddr, e.rempty, e.rlevel);
         end
      end
      n_checks++;
      if (bus.rptr !== 5'b11000 || bus.rempty !== 2'b01 || bus.raddr !== 4'd0) begin
         n_fail++;
         $display("FAIL drain_wrap: got rptr=%b rempty=%b raddr=%0d, need rptr=11000 rempty=01 raddr=0",
                  bus.rptr, bus.rempty, bus.raddr);
      end
   endtask

   task automatic test_read_while_write();
      obs_t e, o;
      drive(1'b0, 1'b0, wcnt + 3);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e || o.rlevel !== 5'd3) begin
         n_fail++;
         $display("FAIL rww_setup: got rlevel=%0d, need rlevel=%0d", o.rlevel, e.rlevel);
      end
      drive(1'b1, 1'b0, wcnt + 1);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e || o.rlevel !== 5'd3) begin
         n_fail++;
         $display("FAIL rww: got rptr=%b rlevel=%0d rempty=%b, need rptr=%b rlevel=3 rempty=%b",
                  o.rptr, o.rlevel, o.rempty, e.rptr, e.rempty);
      end
   endtask

   task automatic test_random_traffic();
      obs_t e, o;
      int   w;
      for (int i = 0; i < 300; i++) begin
         w = wcnt;
         if ((wcnt - m_rbin) < 16 && $urandom_range(0, 1) == 1) w = wcnt + 1;
         drive(logic'($urandom_range(0, 1)), 1'b0, w);
         e = sb.pop_front(); o = sample(); n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random[%0d]: got rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b, need rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b",
                     i, o.rptr, o.raddr, o.rempty, o.rlevel, o.runder, e.rptr, e.raddr, e.rempty, e.rlevel, e.runder);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t e, o;
      drive(1'b0, 1'b1, 0);
      void'(sb.pop_front());
      drive(1'b0, 1'b0, 10);
      void'(sb.pop_front());
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, 10);
         void'(sb.pop_front());
      end
      n_checks++;
      if (bus.rptr !== gray5(5'd7)) begin
         n_fail++;
         $display("FAIL mid_setup: got rptr=%b, need rptr=%b", bus.rptr, gray5(5'd7));
      end
      drive(1'b1, 1'b1, 10);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_mid: got rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b, need rptr=%b raddr=%0d rempty=%b rlevel=%0d und=%b",
                  o.rptr, o.raddr, o.rempty, o.rlevel, o.runder, e.rptr, e.raddr, e.rempty, e.rlevel, e.runder);
      end
      drive(1'b0, 1'b0, 10);
      e = sb.pop_front(); o = sample(); n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL after_reset: got rptr=%b rlevel=%0d rempty=%b, need rptr=%b rlevel=%0d rempty=%b",
                  o.rptr, o.rlevel, o.rempty, e.rptr, e.rlevel, e.rempty);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      m_rbin       = 0;
      m_empty      = 1'b1;
      wcnt         = 0;
      rrst         = 1'b1;
      bus.rinc     = 1'b0;
      bus.rq2_wptr = '0;
      test_reset();
      test_single();
      test_underflow();
      test_full_drain();
      test_read_while_write();
      test_random_traffic();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, need 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
